alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters: data width fixed at 32, op width fixed at 4 (codes from decode.vh), requester count fixed at 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_op  input  4  requester 0 ALU op code (e.g. ALU_ADD, ALU_SUB).
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result this cycle.
REQ-011 rsp_y  output  32  registered ALU result.
REQ-012 rsp_zero  output  1  registered ALU zero flag.
REQ-013 rsp_id  output  1  index of requester owning the result.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The block SHALL instantiate exactly one alu (ports a, b, op, y, zero) and share it between both requesters.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; no other reachable states.
REQ-017 IDLE: reqN_ready SHALL be asserted combinationally only for the granted port, only when that port's valid is high; at most one ready high per cycle.
REQ-018 IDLE with a handshake: operands, op and grant index SHALL be latched into internal registers; next state EXEC.
REQ-019 IDLE with no valid request: remain IDLE, all ready low.
REQ-020 EXEC: alu SHALL be driven only from the latched registers; y and zero captured into rsp_y/rsp_zero at cycle end; next state RESP.
REQ-021 RESP: rsp_valid SHALL be high; rsp_y, rsp_zero and rsp_id held stable until rsp_ready sampled high.
REQ-022 RESP with rsp_ready high: return to IDLE; no request is accepted in that same cycle.
REQ-023 Latency: handshake at cycle N SHALL produce rsp_valid at cycle N+2; minimum 3 cycles per transaction.
REQ-024 Both ready outputs SHALL be low in EXEC and RESP regardless of requester valids.
REQ-025 rsp_ready SHALL be ignored outside RESP.
REQ-026 Only one port valid in IDLE: that port SHALL be granted.
REQ-027 Tie policy SHALL follow REQ-033/REQ-034.
REQ-028 Op codes SHALL pass through unmodified; undefined codes yield whatever alu produces, with no error flagging.
REQ-029 Requesters SHALL hold valid and operands stable until ready; the block does not check this.

Reset
REQ-030 rst_n low at a rising edge SHALL force IDLE, with rsp_valid=0, rsp_y=0, rsp_zero=0, rsp_id=0, busy=0 and last_grant=1.
REQ-031 Reset asserted during EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-032 After rst_n returns high, a pending request SHALL be accepted in the first cycle sampled out of reset.

Configuration
REQ-033 With ALU_ARB_RR_EN defined: a last_grant register, updated on each request handshake, SHALL resolve ties in favour of the port not equal to last_grant; the first tie after reset goes to port 0.
REQ-034 Without ALU_ARB_RR_EN: fixed priority, port 0 always wins ties, and no last_grant register is implemented.

Verification
REQ-035 Only req0: a=7FFFFFFF, b=7FFFFFFF, op=ALU_SUB, handshake at N -> rsp_valid at N+2, rsp_y=00000000, rsp_zero=1, rsp_id=0.
REQ-036 RR_EN, both valid after reset: req0 ALU_SUB a=5 b=0, req1 ALU_SUB a=0 b=FFFFFFFF, rsp_ready=1 -> first rsp y=00000005 id=0, second rsp y=00000001 zero=0 id=1.
REQ-037 rsp_ready low 5 cycles in RESP with both valids high -> rsp_y/rsp_zero/rsp_id stable, both readies low, busy=1; ready raised -> IDLE next cycle.
REQ-038 rst_n low for one cycle during EXEC -> rsp_valid stays 0, state IDLE; pending req0 accepted on the first cycle after reset.
REQ-039 Macro undefined, both valid for 4 transactions -> all responses rsp_id=0 and req1_ready never asserted.
REQ-040 2000 random a/b on alternating ports with op=ALU_SUB, each response checked against a-b and the zero flag, rsp_id matching the issuing port -> zero mismatches.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter sharing one 32-bit ALU through an
//               IDLE/EXEC/RESP handshake FSM. Define ALU_ARB_RR_EN for
//               round-robin tie-breaking; otherwise port 0 wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y,
  output logic        zero
);

  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_AND  = 4'd2;
  localparam logic [3:0] c_ALU_OR   = 4'd3;
  localparam logic [3:0] c_ALU_XOR  = 4'd4;
  localparam logic [3:0] c_ALU_SLL  = 4'd5;
  localparam logic [3:0] c_ALU_SRL  = 4'd6;
  localparam logic [3:0] c_ALU_SRA  = 4'd7;
  localparam logic [3:0] c_ALU_SLT  = 4'd8;
  localparam logic [3:0] c_ALU_SLTU = 4'd9;

  always_comb begin
    y = 32'd0;
    case (op)
      c_ALU_ADD:  y = a + b;
      c_ALU_SUB:  y = a - b;
      c_ALU_AND:  y = a & b;
      c_ALU_OR:   y = a | b;
      c_ALU_XOR:  y = a ^ b;
      c_ALU_SLL:  y = a << b[4:0];
      c_ALU_SRL:  y = a >> b[4:0];
      c_ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      c_ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      c_ALU_SLTU: y = {31'd0, a < b};
      default:    y = 32'd0;
    endcase
    zero = (y == 32'd0);
  end

endmodule

module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic        rsp_zero,
  output logic        rsp_id,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_op;
  logic        r_id;
  logic [31:0] r_y;
  logic        r_zero;
  logic        w_grant;
  logic        w_hs;
  logic [31:0] w_y;
  logic        w_zero;

`ifdef ALU_ARB_RR_EN
  logic r_last_grant;

  // Reset value 1 makes the first tie after reset go to port 0.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_last_grant <= 1'b1;
    else if (w_hs)
      r_last_grant <= w_grant;
  end

  always_comb begin
    w_grant = ~req0_valid;
    if (req0_valid && req1_valid)
      w_grant = ~r_last_grant;
  end
`else
  always_comb begin
    w_grant = ~req0_valid;
  end
`endif

  // No acceptance while reset is asserted, so a pending request waits for
  // the first cycle out of reset.
  assign w_hs = (r_state == S_IDLE) && rst_n && (req0_valid || req1_valid);

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_hs && !w_grant;
    req1_ready = w_hs && w_grant;
    rsp_valid  = (r_state == S_RESP);
    busy       = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_op   <= 4'd0;
      r_id   <= 1'b0;
      r_y    <= 32'd0;
      r_zero <= 1'b0;
    end else begin
      if (w_hs) begin
        r_a  <= w_grant ? req1_a  : req0_a;
        r_b  <= w_grant ? req1_b  : req0_b;
        r_op <= w_grant ? req1_op : req0_op;
        r_id <= w_grant;
      end
      if (r_state == S_EXEC) begin
        r_y    <= w_y;
        r_zero <= w_zero;
      end
    end
  end

  alu u_alu (
    .a    (r_a),
    .b    (r_b),
    .op   (r_op),
    .y    (w_y),
    .zero (w_zero)
  );

  assign rsp_y    = r_y;
  assign rsp_zero = r_zero;
  assign rsp_id   = r_id;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; tie-break expectations follow ALU_ARB_RR_EN.
`default_nettype none

module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_zero, rsp_id, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One transaction on a single port, checking the N+2 response timing.
  task automatic txn(input logic port, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input logic [31:0] ey, input logic ez);
    int   n;
    logic rdy;
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    n   = 0;
    rdy = port ? req1_ready : req0_ready;
    while (!rdy && n < 8) begin
      tick();
      rdy = port ? req1_ready : req0_ready;
      n++;
    end
    chk("handshake", {31'd0, rdy}, 32'd1);
    if (!rdy) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resp_y", rsp_y, ey);
    chk("resp_zero", {31'd0, rsp_zero}, {31'd0, ez});
    chk("resp_id", {31'd0, rsp_id}, {31'd0, port});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic        exp_id;
    logic [31:0] ra, rb;

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_y", rsp_y, 32'd0);
    chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // rsp_ready outside RESP must not disturb IDLE
    rsp_ready = 1'b1;
    repeat (2) tick();
    chk("idle_ignore_rdy", {31'd0, busy}, 32'd0);
    chk("idle_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    rsp_ready = 1'b0;

    // Both valid after reset: ties follow the configured policy
    req0_a = 32'd5; req0_b = 32'd0;          req0_op = OP_SUB;
    req1_a = 32'd0; req1_b = 32'hFFFF_FFFF;  req1_op = OP_SUB;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      exp_id = i[0];
`else
      exp_id = 1'b0;
`endif
      #1;
      chk("tie_ready0", {31'd0, req0_ready}, {31'd0, ~exp_id});
      chk("tie_ready1", {31'd0, req1_ready}, {31'd0, exp_id});
      tick();
      chk("tie_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("tie_exec_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("tie_resp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("tie_resp_y", rsp_y, exp_id ? 32'd1 : 32'd5);
      chk("tie_resp_zero", {31'd0, rsp_zero}, 32'd0);
      chk("tie_resp_id", {31'd0, rsp_id}, {31'd0, exp_id});
      if (i == 0) begin
        repeat (5) begin
          tick();
          chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
          chk("hold_y", rsp_y, 32'd5);
          chk("hold_zero", {31'd0, rsp_zero}, 32'd0);
          chk("hold_id", {31'd0, rsp_id}, 32'd0);
          chk("hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
          chk("hold_busy", {31'd0, busy}, 32'd1);
        end
      end
      rsp_ready = 1'b1;
      #1;
      chk("resp_exit_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
      rsp_ready = 1'b0;
      chk("resp_exit_idle", {31'd0, busy}, 32'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    txn(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, OP_SUB, 32'h0000_0000, 1'b1);
    txn(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1);
    txn(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND, 32'h00F0_00F0, 1'b0);
    txn(1'b1, 32'h1234_5678, 32'h1234_5678, OP_XOR, 32'h0000_0000, 1'b1);
    txn(1'b0, 32'h8000_0000, 32'd4,         OP_SRA, 32'hF800_0000, 1'b0);
    txn(1'b1, 32'hFFFF_FFFF, 32'd1,         OP_SLT, 32'h0000_0001, 1'b0);
    txn(1'b0, 32'hFFFF_FFFF, 32'd1,         OP_SLTU, 32'h0000_0000, 1'b1);

    // Reset during EXEC drops the operation; the held request is retaken
    req0_a = 32'd9; req0_b = 32'd3; req0_op = OP_SUB; req0_valid = 1'b1;
    #1;
    chk("rst_pre_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    chk("rst_in_exec", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_low_ready", {31'd0, req0_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_y", rsp_y, 32'd0);
    chk("rst_after_ready", {31'd0, req0_ready}, 32'd1);
    txn(1'b0, 32'd9, 32'd3, OP_SUB, 32'd6, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      ra = $urandom;
      rb = (i % 50 == 7) ? ra : $urandom;
      txn(i[0], ra, rb, OP_SUB, ra - rb, ra == rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
